data_memory_responder: RTL and testbench
========================================

// Module: data_memory_responder
// PURPOSE
// - Responder end of the CPU load/store path: accepts LOAD/STORE requests from the processor FSM, performs them on a word-wide data RAM or on the LED I/O register, and returns a response.
// - Sits beside program_memory in SOC; the processor's memory state issues requests and waits for rsp_valid before writeback.
// PARAMETERS
// - WORDS    256           data RAM depth in 32-bit words (power of 2)
// - IO_BIT   22            address bit selecting I/O space (1 = I/O, 0 = RAM)
// - LED_OFF  32'h0000_0004 byte offset of the LED register inside I/O space
// PORTS
// - CLK          in   1   clock, all state on posedge
// - RESET        in   1   synchronous, active-high reset
// - req_valid    in   1   request present
// - req_ready    out  1   responder can accept; high only in IDLE
// - req_write    in   1   1 = store, 0 = load
// - req_address  in   32  byte address
// - req_funct3   in   3   RV32I width/sign code (LB/LH/LW/LBU/LHU, SB/SH/SW)
// - req_wdata    in   32  store data, right-aligned (rs2 value)
// - rsp_valid    out  1   response present; held until rsp_ready
// - rsp_ready    in   1   CPU takes response
// - rsp_rdata    out  32  load result, aligned and sign/zero-extended; 0 for stores/errors
// - rsp_error    out  1   misaligned access or illegal funct3
// - LEDS         out  32  LED register contents
// BEHAVIOUR
// - Reset: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_error=0, LEDS=0. RAM contents not cleared.
// - Accept = req_valid && req_ready on a posedge; request fields captured that edge.
// - FSM IDLE -> (store or error) RESP; IDLE -> (load) READ -> RESP; RESP -> IDLE when rsp_ready.
// - Store latency: RAM/LED written on the accept edge using byte enables; rsp_valid high the next cycle.
// - Load latency: RAM read registered on the edge after accept; rsp_valid high 2 cycles after accept.
// - Word index = address[log2(WORDS)+1:2]; higher RAM address bits ignored (wrap).
// - Byte enables: SB -> 1 lane at addr[1:0], data replicated; SH -> lanes {addr[1],0} pair; SW -> all 4.
// - Load extract: LB/LBU byte at addr[1:0], LH/LHU half at addr[1]; LB/LH sign-extend, LBU/LHU zero-extend.
// - Error: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0; load funct3 in {3,6,7}; store funct3 >2.
//   On error: no write of any kind, rsp_error=1, rsp_rdata=0, goes straight to RESP.
// - I/O space (address[IO_BIT]=1): offset LED_OFF word stores update LEDS (byte enables honoured);
//   loads return LEDS; other I/O offsets read 0, writes dropped, no error.
// - rsp_valid/rsp_rdata/rsp_error stable while rsp_valid && !rsp_ready; req_ready=0 throughout.
// - rsp_valid && rsp_ready: returns to IDLE; next request accepted no earlier than following edge.
// - RESET mid-operation (READ/RESP): immediately IDLE, response discarded; a request presented
//   on the RESET edge is not accepted and performs no write.
// STRUCTURE
// - Shared package: funct3 constants (LB..LHU, SB..SW), IO_BIT, LED_OFF, FSM state encoding.
// - One sub-module: mem_lane_align (combinational) -> store byte enables + lane-shifted wdata,
//   load extract/extend, misalignment/illegal flag. Top keeps FSM, RAM array, LED register.
// TESTING
// - SW 0xDEADBEEF @0x10, then LW @0x10 -> rsp_rdata=0xDEADBEEF, rsp_error=0, rsp_valid 2 cycles after accept.
// - RAM word @0x100 = 0; SB 0xAB @0x101; LW @0x100 -> 0x0000AB00; SH 0x1234 @0x102; LW -> 0x1234AB00.
// - Word = 0x00000080 @0x20: LB @0x20 -> 0xFFFFFF80; LBU @0x20 -> 0x00000080; LH @0x20 -> 0x00000080.
// - LW @0x22 and SH @0x21 -> rsp_error=1, rsp_rdata=0; subsequent LW @0x20 shows word unchanged.
// - SW 0xA5 @ (1<<22)+4 -> LEDS=0x000000A5 next cycle; LW same addr -> 0xA5; RAM word 1 unchanged.
// - Hold rsp_ready=0 for 5 cycles -> rsp_valid/rsp_rdata stable, req_ready=0; assert RESET in READ -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/data_memory_responder_pkg.sv
// Shared definitions for the data memory responder: RV32I funct3 codes,
// I/O decode defaults and the FSM state encoding.
package data_memory_responder_pkg;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;

    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SH  = 3'd1;
    localparam logic [2:0] F3_SW  = 3'd2;

    localparam int          IO_BIT_DEF  = 22;
    localparam logic [31:0] LED_OFF_DEF = 32'h0000_0004;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_RESP
    } state_t;

endpackage

// File: rtl/data_memory_responder_lane_align.sv
// Combinational lane logic: store byte enables and lane-replicated data,
// load byte/half extraction with sign/zero extension, access legality.
module mem_lane_align
    import data_memory_responder_pkg::*;
(
    input  logic        write,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    input  logic [1:0]  ld_addr_lo,
    input  logic [2:0]  ld_funct3,
    input  logic [31:0] ld_word,
    output logic [3:0]  st_be,
    output logic [31:0] st_wdata,
    output logic [31:0] ld_data,
    output logic        err
);

    logic [31:0]        shifted;
    logic signed [7:0]  ld_byte;
    logic signed [15:0] ld_half;

    always_comb begin
        st_be    = 4'b0000;
        st_wdata = wdata;
        err      = 1'b0;
        if (write) begin
            case (funct3)
                F3_SB: begin
                    st_be    = 4'b0001 << addr_lo;
                    st_wdata = {4{wdata[7:0]}};
                end
                F3_SH: begin
                    st_be    = addr_lo[1] ? 4'b1100 : 4'b0011;
                    st_wdata = {2{wdata[15:0]}};
                    err      = addr_lo[0];
                end
                F3_SW: begin
                    st_be = 4'b1111;
                    err   = |addr_lo;
                end
                default: err = 1'b1;
            endcase
        end else begin
            case (funct3)
                F3_LB, F3_LBU: err = 1'b0;
                F3_LH, F3_LHU: err = addr_lo[0];
                F3_LW:         err = |addr_lo;
                default:       err = 1'b1;
            endcase
        end
        // An illegal access must never touch storage
        if (err) st_be = 4'b0000;
    end

    always_comb begin
        shifted = ld_word >> {ld_addr_lo, 3'b000};
        ld_byte = shifted[7:0];
        ld_half = ld_addr_lo[1] ? ld_word[31:16] : ld_word[15:0];
        case (ld_funct3)
            F3_LB:   ld_data = 32'(ld_byte);
            F3_LH:   ld_data = 32'(ld_half);
            F3_LBU:  ld_data = {24'd0, ld_byte};
            F3_LHU:  ld_data = {16'd0, ld_half};
            default: ld_data = ld_word;
        endcase
    end

endmodule

// File: rtl/data_memory_responder.sv
// Load/store responder: request/response FSM in front of a word-wide data RAM
// and a memory-mapped LED register.
module data_memory_responder
    import data_memory_responder_pkg::*;
#(
    parameter int          WORDS   = 256,
    parameter int          IO_BIT  = IO_BIT_DEF,
    parameter logic [31:0] LED_OFF = LED_OFF_DEF
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_address,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic [31:0] LEDS
);

    localparam int IDX_W = $clog2(WORDS);

    state_t state_q, state_d;

    logic [31:0]      ram [WORDS];
    logic             accept;
    logic             is_io;
    logic             led_hit;
    logic [31:0]      io_off;
    logic [IDX_W-1:0] word_idx;
    logic [3:0]       st_be;
    logic [31:0]      st_wdata;
    logic [31:0]      ld_data;
    logic [31:0]      src_word;
    logic             req_err;

    logic [31:0] rd_word_p1;
    logic [1:0]  ld_lo_p1;
    logic [2:0]  ld_f3_p1;
    logic        ld_io_p1;
    logic        ld_led_p1;

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    // A request presented while RESET is high is ignored entirely
    assign accept    = req_valid && req_ready && !RESET;
    assign word_idx  = req_address[IDX_W+1:2];
    assign is_io     = req_address[IO_BIT];

    always_comb begin
        io_off         = req_address;
        io_off[IO_BIT] = 1'b0;
        io_off[1:0]    = 2'b00;
    end

    assign led_hit  = is_io && (io_off == LED_OFF);
    assign src_word = ld_io_p1 ? (ld_led_p1 ? LEDS : 32'd0) : rd_word_p1;

    mem_lane_align u_align (
        .write      (req_write),
        .addr_lo    (req_address[1:0]),
        .funct3     (req_funct3),
        .wdata      (req_wdata),
        .ld_addr_lo (ld_lo_p1),
        .ld_funct3  (ld_f3_p1),
        .ld_word    (src_word),
        .st_be      (st_be),
        .st_wdata   (st_wdata),
        .ld_data    (ld_data),
        .err        (req_err)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = (req_write || req_err) ? ST_RESP : ST_READ;
            ST_READ: state_d = ST_RESP;
            ST_RESP: if (rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Response and LED register: control-visible state, cleared by reset
    always_ff @(posedge CLK) begin
        if (RESET) begin
            rsp_rdata <= 32'd0;
            rsp_error <= 1'b0;
            LEDS      <= 32'd0;
        end else begin
            if (accept) begin
                rsp_rdata <= 32'd0;
                rsp_error <= req_err;
                if (req_write && led_hit) begin
                    for (int i = 0; i < 4; i++)
                        if (st_be[i]) LEDS[8*i +: 8] <= st_wdata[8*i +: 8];
                end
            end
            if (state_q == ST_READ) rsp_rdata <= ld_data;
        end
    end

    // Stage p1: registered RAM read and captured load attributes
    always_ff @(posedge CLK) begin
        if (accept) begin
            rd_word_p1 <= ram[word_idx];
            ld_lo_p1   <= req_address[1:0];
            ld_f3_p1   <= req_funct3;
            ld_io_p1   <= is_io;
            ld_led_p1  <= led_hit;
            if (req_write && !is_io) begin
                for (int i = 0; i < 4; i++)
                    if (st_be[i]) ram[word_idx][8*i +: 8] <= st_wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed scoreboard bench for data_memory_responder.
module tb_data_memory_responder;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_address;
    logic [2:0]  req_funct3;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic [31:0] LEDS;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        string       name;
    } exp_t;

    exp_t exp_q[$];

    data_memory_responder dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_address (req_address),
        .req_funct3  (req_funct3),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_error   (rsp_error),
        .LEDS        (LEDS)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every completed response handshake is matched against the scoreboard
    always @(negedge CLK) begin
        if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got rdata %h err %b expected no response", rsp_rdata, rsp_error);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk({e.name, " rdata"}, rsp_rdata, e.rdata);
                chk({e.name, " err"}, {31'd0, rsp_error}, {31'd0, e.err});
            end
        end
    end

    task automatic do_req(input string name, input bit wr, input logic [31:0] addr,
                          input logic [2:0] f3, input logic [31:0] wd,
                          input logic [31:0] exp_d, input bit exp_e, input int hold);
        int   lat;
        int   w;
        int   exp_lat;
        exp_t e;
        exp_lat = (wr || exp_e) ? 1 : 2;
        @(negedge CLK);
        w = 0;
        while (!req_ready && w < 20) begin
            @(negedge CLK);
            w++;
        end
        chk({name, " req_ready"}, {31'd0, req_ready}, 32'd1);
        req_valid   = 1'b1;
        req_write   = wr;
        req_address = addr;
        req_funct3  = f3;
        req_wdata   = wd;
        rsp_ready   = (hold == 0);
        e.rdata = exp_d;
        e.err   = exp_e;
        e.name  = name;
        exp_q.push_back(e);
        @(posedge CLK);
        #1;
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 10) begin
            @(posedge CLK);
            #1;
            lat++;
        end
        chk({name, " latency"}, 32'(lat), 32'(exp_lat));
        for (int i = 0; i < hold; i++) begin
            @(posedge CLK);
            #1;
            chk({name, " hold valid"}, {31'd0, rsp_valid}, 32'd1);
            chk({name, " hold ready"}, {31'd0, req_ready}, 32'd0);
            chk({name, " hold rdata"}, rsp_rdata, exp_d);
        end
        rsp_ready = 1'b1;
        w = 0;
        while (rsp_valid && w < 10) begin
            @(posedge CLK);
            #1;
            w++;
        end
        chk({name, " rsp done"}, {31'd0, rsp_valid}, 32'd0);
    endtask

    initial begin
        RESET       = 1'b1;
        req_valid   = 1'b0;
        req_write   = 1'b0;
        req_address = 32'd0;
        req_funct3  = 3'd0;
        req_wdata   = 32'd0;
        rsp_ready   = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        chk("reset req_ready", {31'd0, req_ready}, 32'd1);
        chk("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset rsp_rdata", rsp_rdata, 32'd0);
        chk("reset rsp_error", {31'd0, rsp_error}, 32'd0);
        chk("reset LEDS", LEDS, 32'd0);
        RESET = 1'b0;

        // Word store/load
        do_req("sw_10", 1, 32'h10, 3'd2, 32'hDEADBEEF, 32'h0, 0, 0);
        do_req("lw_10", 0, 32'h10, 3'd2, 32'h0, 32'hDEADBEEF, 0, 0);

        // Byte and half stores into a cleared word
        do_req("sw_100", 1, 32'h100, 3'd2, 32'h0, 32'h0, 0, 0);
        do_req("sb_101", 1, 32'h101, 3'd0, 32'hAB, 32'h0, 0, 0);
        do_req("lw_100a", 0, 32'h100, 3'd2, 32'h0, 32'h0000AB00, 0, 0);
        do_req("sh_102", 1, 32'h102, 3'd1, 32'h1234, 32'h0, 0, 0);
        do_req("lw_100b", 0, 32'h100, 3'd2, 32'h0, 32'h1234AB00, 0, 0);

        // Sign/zero extension
        do_req("sw_20", 1, 32'h20, 3'd2, 32'h80, 32'h0, 0, 0);
        do_req("lb_20", 0, 32'h20, 3'd0, 32'h0, 32'hFFFFFF80, 0, 0);
        do_req("lbu_20", 0, 32'h20, 3'd4, 32'h0, 32'h00000080, 0, 0);
        do_req("lh_20", 0, 32'h20, 3'd1, 32'h0, 32'h00000080, 0, 0);
        do_req("lhu_102", 0, 32'h102, 3'd5, 32'h0, 32'h00001234, 0, 0);
        do_req("lb_101", 0, 32'h101, 3'd0, 32'h0, 32'hFFFFFFAB, 0, 0);

        // Misaligned and illegal accesses
        do_req("lw_22_err", 0, 32'h22, 3'd2, 32'h0, 32'h0, 1, 0);
        do_req("sh_21_err", 1, 32'h21, 3'd1, 32'hFFFF, 32'h0, 1, 0);
        do_req("ld_f3_6_err", 0, 32'h20, 3'd6, 32'h0, 32'h0, 1, 0);
        do_req("st_f3_3_err", 1, 32'h20, 3'd3, 32'hFFFFFFFF, 32'h0, 1, 0);
        do_req("lw_20_after", 0, 32'h20, 3'd2, 32'h0, 32'h00000080, 0, 0);

        // LED register and I/O space
        do_req("sw_4", 1, 32'h4, 3'd2, 32'h5A5A5A5A, 32'h0, 0, 0);
        do_req("sw_led", 1, 32'h0040_0004, 3'd2, 32'hA5, 32'h0, 0, 0);
        chk("leds after sw", LEDS, 32'h000000A5);
        do_req("lw_led", 0, 32'h0040_0004, 3'd2, 32'h0, 32'h000000A5, 0, 0);
        do_req("lw_4", 0, 32'h4, 3'd2, 32'h0, 32'h5A5A5A5A, 0, 0);
        do_req("lb_led", 0, 32'h0040_0004, 3'd0, 32'h0, 32'hFFFFFFA5, 0, 0);
        do_req("sb_led", 1, 32'h0040_0005, 3'd0, 32'h07, 32'h0, 0, 0);
        chk("leds after sb", LEDS, 32'h000007A5);
        do_req("sw_io8", 1, 32'h0040_0008, 3'd2, 32'hFFFFFFFF, 32'h0, 0, 0);
        chk("leds after io8", LEDS, 32'h000007A5);
        do_req("lw_io8", 0, 32'h0040_0008, 3'd2, 32'h0, 32'h0, 0, 0);

        // Address wrap above the RAM depth
        do_req("lw_410_wrap", 0, 32'h410, 3'd2, 32'h0, 32'hDEADBEEF, 0, 0);

        // Backpressure
        do_req("lw_hold", 0, 32'h100, 3'd2, 32'h0, 32'h1234AB00, 0, 5);

        // Reset during READ discards the response; request on reset edge is ignored
        do_req("sw_30", 1, 32'h30, 3'd2, 32'h11111111, 32'h0, 0, 0);
        @(negedge CLK);
        req_valid   = 1'b1;
        req_write   = 1'b0;
        req_address = 32'h10;
        req_funct3  = 3'd2;
        @(posedge CLK);
        #1;
        req_valid = 1'b0;
        chk("read state ready", {31'd0, req_ready}, 32'd0);
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        chk("mid reset req_ready", {31'd0, req_ready}, 32'd1);
        chk("mid reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("mid reset rsp_rdata", rsp_rdata, 32'd0);
        chk("mid reset rsp_error", {31'd0, rsp_error}, 32'd0);
        chk("mid reset LEDS", LEDS, 32'd0);
        @(negedge CLK);
        req_valid   = 1'b1;
        req_write   = 1'b1;
        req_address = 32'h30;
        req_funct3  = 3'd2;
        req_wdata   = 32'h22222222;
        @(posedge CLK);
        #1;
        req_valid = 1'b0;
        RESET     = 1'b0;
        chk("reset edge rsp_valid", {31'd0, rsp_valid}, 32'd0);
        do_req("lw_30", 0, 32'h30, 3'd2, 32'h0, 32'h11111111, 0, 0);

        repeat (3) @(posedge CLK);
        chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
